// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
//   - uart_state_e : frame sequencing states
//   - PARITY_*     : parity mode encodings for the PARITY parameter
//   - bit_cycles() : clocks per bit for a given clock frequency and baud rate
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Integer division: any fractional remainder shows up as baud-rate error.
    function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART.
// Counts clocks 0..BIT_CYCLES-1 and raises tick while the count sits at its last value,
// so the consumer advances on the edge that closes each bit period.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   clear - synchronous clear; restarts the bit period (used at frame start / while idle)
//   tick  - high during the final clock of each bit period
module uart_baud_tick #(
    parameter int unsigned BIT_CYCLES = 1085,
    parameter int unsigned CNT_W      = $clog2(BIT_CYCLES * 2)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte per valid/ready handshake and sends it as
// start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset; aborts any frame in progress
//   tx_data  - byte to send, sampled only on the handshake cycle
//   tx_valid - producer has a byte
//   tx_ready - registered; high while idle and able to accept a byte
//   tx       - registered serial output, idles high
//   tx_busy  - registered; high while a frame is in progress
//   tx_done  - one-cycle pulse after the last stop bit completes
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 125000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned PARITY    = PARITY_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W      = $clog2(BIT_CYCLES * 2);
    localparam logic [2:0]  LAST_STOP  = 3'(STOP_BITS - 1);
    localparam logic        HAS_PARITY = (PARITY != PARITY_NONE);

    if (PARITY > PARITY_EVEN) begin : gen_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (BIT_CYCLES < 1) begin : gen_bad_baud
        $error("uart_tx: BAUD_RATE must not exceed CLK_FREQ");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick;

    // Holding the timer cleared while idle aligns bit timing to the handshake edge.
    uart_baud_tick #(
        .BIT_CYCLES (BIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == StIdle),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    par_d   = (PARITY == PARITY_ODD) ? ~(^tx_data) : ^tx_data;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (HAS_PARITY) begin
                            tx_d    = par_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        // shift_q[0] is on the line; the next bit is one place up.
                        tx_d    = shift_q[1];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                // bit_q counts stop bits here.
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = StIdle;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
